frac_n_divider_sync: RTL and testbench
======================================

// Module: frac_n_divider_sync
// PURPOSE
//  Single-clock fractional-N divider. Successor to the first-generation MASH divider.
//  Divides clk by (I + F/2^WIDTH_MODULUS) using an inline MASH 1-1..1 of configurable order (1..4).
//  Adds the following:
//   - glitch-free shadow-register update with handshake
//   - clamped count target
//   - square-wave output alongside the pulse output
//  Sits between the PLL prescaler clock (clk) and the phase/frequency detector input.
// PARAMETERS
//  WIDTH_INTEGER   10                           integer part width (I)
//  WIDTH_MODULUS   16                           fractional part width (F), modulus = 2^WIDTH_MODULUS
//  ORDER           3                            MASH order, legal 1..4; others are a elaboration-time $error
//  DATA_WIDTH      WIDTH_INTEGER+WIDTH_MODULUS  divide word width, {I,F}
//  DEFAULT_DIVIDE  {10'd10,16'd0}               active divide word after reset
//  MIN_COUNT       3                            lowest allowed count target, >= 2
// PORTS
//  clk            in   1                 divider input clock, sole clock
//  rst            in   1                 synchronous, active-high reset
//  divide_value   in   DATA_WIDTH        new {I,F} word, sampled when load=1
//  load           in   1                 1-cycle request to stage divide_value
//  load_ack       out  1                 1-cycle pulse: staged word became active
//  div_pulse      out  1                 1-cycle pulse once per output period
//  div_square     out  1                 ~50% duty output, same period as div_pulse
//  mash_out       out  ORDER+1 (signed)  registered MASH correction for the current period
//  count_target   out  WIDTH_INTEGER     clamped terminal count for the current period
//  dither_out     out  1                 current dither bit; only when FRAC_DIV_DITHER_EN is defined
//  dither_en      in   1                 enable LFSR dither; only when FRAC_DIV_DITHER_EN is defined
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): clears all state.
//   - count=0, mash accumulators=0, mash_out=0
//   - active word=DEFAULT_DIVIDE, shadow empty
//   - div_pulse=0, div_square=1, load_ack=0, dither_out=0, LFSR=seed 1
//   - Reset mid-period abandons the period; the first post-reset period uses DEFAULT_DIVIDE with mash_out=0.
//  Counter: count increments each clk. Terminal count (TC) is count==count_target.
//   - At TC: count<=0 and div_pulse<=1 for exactly one cycle.
//   - Period = count_target+1 clk cycles.
//  count_target = clamp(I_active + sext(mash_out), MIN_COUNT, 2^WIDTH_INTEGER-1). Arithmetic is done in WIDTH_INTEGER+2 signed bits.
//  MASH advances only at TC (clock-enabled), never otherwise.
//   - Stage k accumulator is WIDTH_MODULUS bits and wraps mod 2^WIDTH_MODULUS; carry c_k.
//   - Stage 1 input is F_active (+dither); stage k>1 input is the stage k-1 residue.
//   - y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3 + (1-z^-1)^3 c4.
//   - Per-stage differentiator delays also update only at TC.
//   - y is registered into mash_out at TC, so mash_out and count_target are constant for a whole period.
//   - mash_out range: ORDER=1 gives 0..1; ORDER=2 gives -1..2; ORDER=3 gives -3..4; ORDER=4 gives -7..8.
//  Update handshake:
//   - load=1 writes divide_value into the shadow register and sets pending.
//   - At the next TC with pending set, the shadow becomes active; load_ack pulses in the same cycle as div_pulse; pending is cleared.
//   - The new word affects the MASH update at that TC and the following period's count_target.
//   - Multiple loads before TC: last write wins and only one ack is issued.
//   - load in the TC cycle itself: the new value is captured but not applied until the next TC. The old shadow, if pending, is applied now.
//  div_square is 1 while count <= count_target>>1, else 0. For odd periods the high phase is one cycle longer.
//  F_active=0 and ORDER any: mash_out stays 0 and the period is exactly I+1 (integer-N mode).
// CONFIGURATION
//  FRAC_DIV_DITHER_EN defined:
//   - Adds dither_en/dither_out and a 23-bit Fibonacci LFSR (x^23+x^18+1).
//   - The LFSR steps at TC when dither_en=1.
//   - dither_out is the registered LSB of the LFSR, added to the stage-1 input (F+dither, wraps mod 2^WIDTH_MODULUS).
//   - dither_en=0 freezes the LFSR and forces the dither bit to 0.
//  FRAC_DIV_DITHER_EN undefined: no dither ports or logic; the stage-1 input is F_active exactly.
// STRUCTURE
//  Shared package frac_div_pkg holds:
//   - MASH_MAX_ORDER=4 and LFSR_WIDTH=23 / LFSR_TAP=18
//   - clamp function and mash output range constants per order
//  Sub-module frac_mash_stage: one accumulator + carry + differentiator chain element, clock-enabled, generated ORDER times.
//  The top level holds the shadow/handshake, counter, clamp, output regs and LFSR.
// TESTING
//  T1: Word {10,0}, ORDER=3.
//   - div_pulse every 11 clks.
//   - mash_out=0 throughout.
//   - div_square high 6 clks, low 5.
//  T2: ORDER=1, {10,16'h8000}.
//   - Periods alternate 11,12.
//   - Over 1000 periods the average is 11.5 exactly.
//   - mash_out alternates 0/1.
//  T3: ORDER=3, {20,16'h4000}.
//   - Sum of periods over 2^16 pulses equals 2^16*21.25.
//   - mash_out stays within -3..4.
//  T4: Load {15,0} at count=4 of an 11-cycle period.
//   - Current period stays 11.
//   - load_ack coincides with that div_pulse.
//   - Next periods are 16.
//   - A second load before TC overrides the first and produces one ack.
//  T5: ORDER=3, {2,16'hFFFF}.
//   - count_target never goes below MIN_COUNT=3.
//   - Never exceeds 1023 at {1023,16'hFFFF}.
//  T6: rst mid-period (count=7).
//   - Next cycle: count=0, div_pulse=0, div_square=1, mash_out=0.
//   - First period is 11 (DEFAULT_DIVIDE).
//   - Under FRAC_DIV_DITHER_EN with dither_en=1, F=0 gives a nonzero mash_out within 2^10 pulses.

Source files
------------

// File: rtl/frac_div_pkg.sv
// +--------------------------------------------------------------------------+
// | frac_div_pkg: shared constants and helpers for the fractional-N divider.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package frac_div_pkg;

   localparam int MASH_MAX_ORDER = 4;
   localparam int LFSR_WIDTH     = 23;
   localparam int LFSR_TAP       = 18;
   localparam int MASH_Y_W       = MASH_MAX_ORDER + 2;

   function automatic int frac_div_clamp(input int value, input int lo, input int hi);
      if (value < lo) return lo;
      if (value > hi) return hi;
      return value;
   endfunction

   function automatic int mash_out_min(input int order);
      return 1 - (1 << (order - 1));
   endfunction

   function automatic int mash_out_max(input int order);
      return 1 << (order - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/frac_mash_stage.sv
// +--------------------------------------------------------------------------+
// | frac_mash_stage: one MASH accumulator with carry and differentiator link. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module frac_mash_stage #(
   parameter int WIDTH   = 16,
   parameter int Y_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_i,
   input  logic [WIDTH-1:0]          data_i,
   input  logic signed [Y_WIDTH-1:0] y_next_i,
   output logic [WIDTH-1:0]          residue_o,
   output logic signed [Y_WIDTH-1:0] y_o
);

   logic [WIDTH-1:0]          acc_q;
   logic signed [Y_WIDTH-1:0] y_next_q;
   logic [WIDTH:0]            w_sum;
   logic                      w_carry;

   assign w_sum     = {1'b0, acc_q} + {1'b0, data_i};
   assign w_carry   = w_sum[WIDTH];
   assign residue_o = w_sum[WIDTH-1:0];

   // Own carry plus first difference of the downstream stage's output.
   assign y_o = $signed({{(Y_WIDTH-1){1'b0}}, w_carry}) + y_next_i - y_next_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         y_next_q <= '0;
      end else if (en_i) begin
         acc_q    <= w_sum[WIDTH-1:0];
         y_next_q <= y_next_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/frac_n_divider_sync.sv
// +--------------------------------------------------------------------------+
// | frac_n_divider_sync: single-clock MASH fractional-N divider with shadow   |
// | update handshake. Optional LFSR dither under FRAC_DIV_DITHER_EN.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module frac_n_divider_sync
   import frac_div_pkg::*;
#(
   parameter int                      WIDTH_INTEGER  = 10,
   parameter int                      WIDTH_MODULUS  = 16,
   parameter int                      ORDER          = 3,
   parameter int                      DATA_WIDTH     = WIDTH_INTEGER + WIDTH_MODULUS,
   parameter logic [DATA_WIDTH-1:0]   DEFAULT_DIVIDE = DATA_WIDTH'(10) << WIDTH_MODULUS,
   parameter int                      MIN_COUNT      = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    divide_value,
   input  logic                     load,
`ifdef FRAC_DIV_DITHER_EN
   input  logic                     dither_en,
   output logic                     dither_out,
`endif
   output logic                     load_ack,
   output logic                     div_pulse,
   output logic                     div_square,
   output logic signed [ORDER:0]    mash_out,
   output logic [WIDTH_INTEGER-1:0] count_target
);

   localparam int YW = MASH_Y_W;

   if (ORDER < 1 || ORDER > MASH_MAX_ORDER) begin : g_bad_order
      $error("frac_n_divider_sync: ORDER must be in 1..4");
   end

   logic [WIDTH_INTEGER-1:0]        count_q, count_d;
   logic [WIDTH_INTEGER-1:0]        act_i_q, act_i_d;
   logic [WIDTH_MODULUS-1:0]        act_f_q, act_f_d;
   logic [DATA_WIDTH-1:0]           shadow_q, shadow_d;
   logic                            pending_q, pending_d;
   logic                            div_pulse_q, load_ack_q;
   logic signed [ORDER:0]           mash_out_q, mash_out_d;

   logic                            w_tc;
   logic                            w_apply;
   logic signed [WIDTH_INTEGER+1:0] w_target_sum;
   logic [WIDTH_MODULUS-1:0]        w_dither;
   logic [WIDTH_MODULUS-1:0]        w_res [0:ORDER];
   logic signed [YW-1:0]            w_y   [1:ORDER+1];
   logic                            w_unused;

   assign w_target_sum = $signed({2'b00, act_i_q})
                       + $signed({{(WIDTH_INTEGER+1-ORDER){mash_out_q[ORDER]}}, mash_out_q});
   assign count_target = WIDTH_INTEGER'(frac_div_clamp(int'(w_target_sum), MIN_COUNT,
                                                       (1 << WIDTH_INTEGER) - 1));

   assign w_tc    = (count_q == count_target);
   assign w_apply = w_tc & pending_q;

   // A word promoted at this TC already drives this TC's MASH step.
   assign w_res[0]       = (w_apply ? shadow_q[WIDTH_MODULUS-1:0] : act_f_q) + w_dither;
   assign w_y[ORDER+1]   = '0;

   for (genvar k = 1; k <= ORDER; k++) begin : g_stage
      frac_mash_stage #(
         .WIDTH   (WIDTH_MODULUS),
         .Y_WIDTH (YW)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en_i      (w_tc),
         .data_i    (w_res[k-1]),
         .y_next_i  (w_y[k+1]),
         .residue_o (w_res[k]),
         .y_o       (w_y[k])
      );
   end

   assign w_unused = ^{w_res[ORDER], w_y[1][YW-1:ORDER+1]};

`ifdef FRAC_DIV_DITHER_EN
   logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
   logic                  dither_q, dither_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (w_tc && dither_en) begin
         lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], lfsr_q[LFSR_WIDTH-1] ^ lfsr_q[LFSR_TAP-1]};
      end
      dither_d = dither_en & lfsr_q[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q   <= LFSR_WIDTH'(1);
         dither_q <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         dither_q <= dither_d;
      end
   end

   assign w_dither   = {{(WIDTH_MODULUS-1){1'b0}}, dither_q};
   assign dither_out = dither_q;
`else
   assign w_dither = '0;
`endif

   always_comb begin
      count_d              = w_tc ? '0 : count_q + WIDTH_INTEGER'(1);
      pending_d            = load | (pending_q & ~w_tc);
      shadow_d             = load ? divide_value : shadow_q;
      {act_i_d, act_f_d}   = w_apply ? shadow_q : {act_i_q, act_f_q};
      mash_out_d           = w_tc ? w_y[1][ORDER:0] : mash_out_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q            <= '0;
         {act_i_q, act_f_q} <= DEFAULT_DIVIDE;
         shadow_q           <= '0;
         pending_q          <= 1'b0;
         div_pulse_q        <= 1'b0;
         load_ack_q         <= 1'b0;
         mash_out_q         <= '0;
      end else begin
         count_q            <= count_d;
         act_i_q            <= act_i_d;
         act_f_q            <= act_f_d;
         shadow_q           <= shadow_d;
         pending_q          <= pending_d;
         div_pulse_q        <= w_tc;
         load_ack_q         <= w_apply;
         mash_out_q         <= mash_out_d;
      end
   end

   assign div_pulse  = div_pulse_q;
   assign load_ack   = load_ack_q;
   assign mash_out   = mash_out_q;
   assign div_square = (count_q <= (count_target >> 1));

endmodule

`default_nettype wire

// File: tb/tb_frac_n_divider_sync.sv
// +--------------------------------------------------------------------------+
// | tb_frac_n_divider_sync: directed and random checks of the divider against |
// | an arithmetic MASH/period model. Revision: 1.0                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_frac_n_divider_sync;

   localparam int WI   = 10;
   localparam int WM   = 16;
   localparam int ORD  = 3;
   localparam int DW   = WI + WM;
   localparam int MINC = 3;
   localparam int MOD  = 1 << WM;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 load;
   logic [DW-1:0]        divide_value;
   logic                 load_ack, div_pulse, div_square;
   logic signed [ORD:0]  mash_out;
   logic [WI-1:0]        count_target;
`ifdef FRAC_DIV_DITHER_EN
   logic                 dither_en;
   logic                 dither_out;
`endif

   frac_n_divider_sync #(
      .WIDTH_INTEGER (WI),
      .WIDTH_MODULUS (WM),
      .ORDER         (ORD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .divide_value (divide_value),
      .load         (load),
`ifdef FRAC_DIV_DITHER_EN
      .dither_en    (dither_en),
      .dither_out   (dither_out),
`endif
      .load_ack     (load_ack),
      .div_pulse    (div_pulse),
      .div_square   (div_square),
      .mash_out     (mash_out),
      .count_target (count_target)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference state: active word, shadow, accumulators and carry history
   int            m_i, m_f, m_mash, cur_tgt;
   logic [DW-1:0] m_sh;
   bit            m_pend;
   int            acc [1:4];
   int            ch  [1:4][0:3];

   function automatic int clampv(input int v);
      if (v < MINC) return MINC;
      if (v > (1 << WI) - 1) return (1 << WI) - 1;
      return v;
   endfunction

   function automatic int binom(input int n, input int k);
      int r = 1;
      for (int j = 0; j < k; j++) r = r * (n - j) / (j + 1);
      return r;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_i = 10; m_f = 0; m_sh = '0; m_pend = 0; m_mash = 0; cur_tgt = 10;
      for (int k = 1; k <= 4; k++) begin
         acc[k] = 0;
         for (int j = 0; j < 4; j++) ch[k][j] = 0;
      end
   endtask

   // y = sum_k (1 - z^-1)^(k-1) c_k, expanded binomially over carry history
   task automatic mash_step(input int f);
      int e, s, y;
      e = f;
      for (int k = 1; k <= ORD; k++) begin
         for (int j = 3; j > 0; j--) ch[k][j] = ch[k][j-1];
         s        = acc[k] + e;
         ch[k][0] = (s >= MOD) ? 1 : 0;
         acc[k]   = s % MOD;
         e        = acc[k];
      end
      y = 0;
      for (int k = 1; k <= ORD; k++)
         for (int j = 0; j < k; j++)
            y += ((j % 2 == 0) ? 1 : -1) * binom(k - 1, j) * ch[k][j];
      m_mash = y;
   endtask

   task automatic model_load(input logic [DW-1:0] v);
      m_sh   = v;
      m_pend = 1;
   endtask

   // Runs one output period from the cycle where the previous pulse (or reset) was seen.
   task automatic run_period(input int la1, input logic [DW-1:0] lv1,
                             input int la2, input logic [DW-1:0] lv2);
      int n, hi, exp_len, exp_hi;
      bit ack;
      exp_len = cur_tgt + 1;
      exp_hi  = (cur_tgt >> 1) + 1;
      n = 0; hi = 0;
      while (1) begin
         load = 1'b0;
         if (n == la1) begin load = 1'b1; divide_value = lv1; end
         if (n == la2) begin load = 1'b1; divide_value = lv2; end
         @(negedge clk);
         n++;
         if (div_square) hi++;
         if (div_pulse || n > 2100) break;
      end
      load = 1'b0;
      if (la1 >= 0 && la1 < exp_len - 1) model_load(lv1);
      if (la2 >= 0 && la2 < exp_len - 1) model_load(lv2);
      ack = m_pend;
      if (m_pend) begin
         m_i    = int'(m_sh[DW-1:WM]);
         m_f    = int'(m_sh[WM-1:0]);
         m_pend = 0;
      end
      mash_step(m_f);
      if (la1 == exp_len - 1) model_load(lv1);
      if (la2 == exp_len - 1) model_load(lv2);
      check("period", n, exp_len);
      check("square_high", hi, exp_hi);
      check("load_ack", int'(load_ack), int'(ack));
      check("mash_out", int'(mash_out), m_mash);
      check("count_target", int'(count_target), clampv(m_i + m_mash));
      check("mash_in_range", int'(int'(mash_out) >= -3 && int'(mash_out) <= 4), 1);
      cur_tgt = clampv(m_i + m_mash);
   endtask

   task automatic run_plain(input int cnt);
      for (int p = 0; p < cnt; p++) run_period(-1, '0, -1, '0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pulse"},  int'(div_pulse), 0);
      check({tag, "_square"}, int'(div_square), 1);
      check({tag, "_mash"},   int'(mash_out), 0);
      check({tag, "_ack"},    int'(load_ack), 0);
      check({tag, "_target"}, int'(count_target), 10);
`ifdef FRAC_DIV_DITHER_EN
      check({tag, "_dither"}, int'(dither_out), 0);
`endif
   endtask

   function automatic logic [DW-1:0] word(input int i, input int f);
      logic [31:0] iv, fv;
      iv = i; fv = f;
      return {iv[WI-1:0], fv[WM-1:0]};
   endfunction

   initial begin
      int ri, rf, mode, la1, la2;
      rst = 1'b1; load = 1'b0; divide_value = '0;
`ifdef FRAC_DIV_DITHER_EN
      dither_en = 1'b0;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset");

      // integer-N default word
      run_plain(5);

      // load mid-period, then override-before-TC with a single ack
      run_period(4, word(15, 0), -1, '0);
      run_plain(3);
      run_period(2, word(20, 'h4000), 9, word(12, 0));
      run_plain(3);

      // load in the TC cycle itself is deferred to the following TC
      run_period(cur_tgt, word(10, 'h8000), -1, '0);
      run_plain(20);
      run_period(cur_tgt - 2, word(20, 'h4000), cur_tgt, word(7, 'h1234));
      run_plain(12);

      // clamp boundaries
      run_period(1, word(2, 'hFFFF), -1, '0);
      run_plain(16);
      run_period(0, word(0, 0), -1, '0);
      run_plain(3);
      run_period(1, word(1023, 'hFFFF), -1, '0);
      run_plain(3);

      // random words and load positions
      for (int it = 0; it < 25; it++) begin
         ri   = $urandom_range(2, 30);
         rf   = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, MOD - 1));
         mode = $urandom_range(0, 2);
         la1  = $urandom_range(0, cur_tgt);
         la2  = -1;
         if (mode == 2 && la1 < cur_tgt) la2 = $urandom_range(la1 + 1, cur_tgt);
         if (la2 >= 0)
            run_period(la1, word(($urandom_range(2, 30)), $urandom_range(0, MOD - 1)),
                       la2, word(ri, rf));
         else
            run_period(la1, word(ri, rf), -1, '0);
         run_plain(6);
      end

      // reset in the middle of a period
      run_plain(1);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_reset_state("midreset");
      run_plain(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
